// File: rtl/spi_rgb_ctrl.sv
// spi_rgb_ctrl: SPI byte command decoder and RGB PWM driver
// feeding the SB_RGBA_DRV primitive on the iCE40UP5K.
module spi_rgb_ctrl #(
    parameter int unsigned PWM_DIV   = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic       led_en,
    output logic       frame_err,
    output logic [7:0] cmd_count
);

    localparam logic [15:0] DIV_LAST = 16'(PWM_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, SET_R, SET_G, SET_B,
        RD_G, RD_B, RD_END, EN, DROP
    } state_t;

    state_t      state_q;
    logic        frame_q;
    logic [7:0]  tx_q;
    logic [7:0]  cmd_q;
    logic        led_q;
    logic        err_q;
    logic [7:0]  shd_r_q;
    logic [7:0]  shd_g_q;
    logic [7:0]  pend_r_q;
    logic [7:0]  pend_g_q;
    logic [7:0]  pend_b_q;
    logic [7:0]  duty_r_q;
    logic [7:0]  duty_g_q;
    logic [7:0]  duty_b_q;
    logic [15:0] presc_q;
    logic [15:0] presc_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        tick;
    logic        wrap;
    logic        pwm_r_q;
    logic        pwm_g_q;
    logic        pwm_b_q;
    logic        frame_end;
    logic        accept;

    // A falling SS always wins over a byte in the same cycle
    assign frame_end = frame_q & ~frame_active;
    assign accept    = rx_valid & frame_active;

    // Prescaler and PWM step counter next-state
    always_comb begin
        tick    = (presc_q == DIV_LAST);
        wrap    = tick && (cnt_q == 8'hFF);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
    end

    // Command FSM with registered tx byte, status and pending duties
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            frame_q  <= 1'b0;
            tx_q     <= SYNC_BYTE;
            cmd_q    <= 8'd0;
            led_q    <= 1'b0;
            err_q    <= 1'b0;
            shd_r_q  <= 8'd0;
            shd_g_q  <= 8'd0;
            pend_r_q <= 8'd0;
            pend_g_q <= 8'd0;
            pend_b_q <= 8'd0;
        end else begin
            frame_q <= frame_active;
            err_q   <= 1'b0;
            if (frame_end) begin
                state_q <= IDLE;
                tx_q    <= SYNC_BYTE;
                err_q   <= (state_q == SET_R) ||
                           (state_q == SET_G) ||
                           (state_q == SET_B) ||
                           (state_q == EN);
            end else if (accept) begin
                unique case (state_q)
                    IDLE: begin
                        unique case (rx_data)
                            8'h01: state_q <= SET_R;
                            8'h02: begin
                                tx_q    <= duty_r_q;
                                state_q <= RD_G;
                            end
                            8'h03: state_q <= EN;
                            default: begin
                                err_q   <= 1'b1;
                                tx_q    <= 8'h00;
                                state_q <= DROP;
                            end
                        endcase
                    end
                    SET_R: begin
                        shd_r_q <= rx_data;
                        state_q <= SET_G;
                    end
                    SET_G: begin
                        shd_g_q <= rx_data;
                        state_q <= SET_B;
                    end
                    SET_B: begin
                        pend_r_q <= shd_r_q;
                        pend_g_q <= shd_g_q;
                        pend_b_q <= rx_data;
                        cmd_q    <= cmd_q + 8'd1;
                        tx_q     <= 8'h00;
                        state_q  <= DROP;
                    end
                    RD_G: begin
                        tx_q    <= duty_g_q;
                        state_q <= RD_B;
                    end
                    RD_B: begin
                        tx_q    <= duty_b_q;
                        cmd_q   <= cmd_q + 8'd1;
                        state_q <= RD_END;
                    end
                    RD_END: begin
                        tx_q    <= 8'h00;
                        state_q <= DROP;
                    end
                    EN: begin
                        led_q   <= rx_data[0];
                        cmd_q   <= cmd_q + 8'd1;
                        tx_q    <= 8'h00;
                        state_q <= DROP;
                    end
                    DROP: tx_q <= 8'h00;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // PWM counter, period-aligned duty reload, registered compare
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q  <= 16'd0;
            cnt_q    <= 8'd0;
            duty_r_q <= 8'd0;
            duty_g_q <= 8'd0;
            duty_b_q <= 8'd0;
            pwm_r_q  <= 1'b0;
            pwm_g_q  <= 1'b0;
            pwm_b_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            if (wrap) begin
                duty_r_q <= pend_r_q;
                duty_g_q <= pend_g_q;
                duty_b_q <= pend_b_q;
            end
            pwm_r_q <= (cnt_q < duty_r_q);
            pwm_g_q <= (cnt_q < duty_g_q);
            pwm_b_q <= (cnt_q < duty_b_q);
        end
    end

    assign tx_data   = tx_q;
    assign pwm_r     = pwm_r_q;
    assign pwm_g     = pwm_g_q;
    assign pwm_b     = pwm_b_q;
    assign led_en    = led_q;
    assign frame_err = err_q;
    assign cmd_count = cmd_q;

endmodule

// File: tb/tb_spi_rgb_ctrl.sv
// tb_spi_rgb_ctrl: randomized self-checking bench for spi_rgb_ctrl
// against a frame-level model of commands, duties and PWM counts.
module tb_spi_rgb_ctrl;

    localparam int unsigned PWM_DIV = 1;
    localparam logic [7:0]  SYNC    = 8'hA5;

    logic       clk;
    logic       resetn;
    logic       frame_active;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       pwm_r;
    logic       pwm_g;
    logic       pwm_b;
    logic       led_en;
    logic       frame_err;
    logic [7:0] cmd_count;

    int passed;
    int total;
    int errs;

    logic [7:0] m_pend [3];
    logic [7:0] m_act  [3];
    logic [7:0] m_sh   [2];
    logic       m_led;
    logic [7:0] m_cmd;
    logic [7:0] ph;

    spi_rgb_ctrl #(
        .PWM_DIV  (PWM_DIV),
        .SYNC_BYTE(SYNC)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_active(frame_active),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_data     (tx_data),
        .pwm_r       (pwm_r),
        .pwm_g       (pwm_g),
        .pwm_b       (pwm_b),
        .led_en      (led_en),
        .frame_err   (frame_err),
        .cmd_count   (cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PWM phase since reset release (one step per clk at PWM_DIV=1)
    always @(posedge clk or negedge resetn) begin
        if (!resetn) ph <= 8'd0;
        else         ph <= ph + 8'd1;
    end

    always @(negedge clk) begin
        if (frame_err === 1'b1) errs = errs + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);
    endtask

    task automatic frame_start();
        frame_active = 1'b1;
        clk_n(2);
    endtask

    task automatic frame_end();
        frame_active = 1'b0;
        clk_n(3);
    endtask

    task automatic settle();
        clk_n(256 * PWM_DIV + 8);
        for (int i = 0; i < 3; i++) m_act[i] = m_pend[i];
    endtask

    task automatic measure(output int hr, output int hg,
                           output int hb);
        hr = 0;
        hg = 0;
        hb = 0;
        repeat (256 * PWM_DIV) begin
            @(negedge clk);
            hr += int'(pwm_r);
            hg += int'(pwm_g);
            hb += int'(pwm_b);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = 8'd0;
            m_act[i]  = 8'd0;
        end
        m_sh[0] = 8'd0;
        m_sh[1] = 8'd0;
        m_led   = 1'b0;
        m_cmd   = 8'd0;
    endtask

    task automatic test_reset();
        int hi;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        model_reset();
        clk_n(3);
        total++;
        if (tx_data !== SYNC)
            $display("FAIL rst_tx got %h want %h", tx_data, SYNC);
        else passed++;
        total++;
        if ({pwm_r, pwm_g, pwm_b} !== 3'b000)
            $display("FAIL rst_pwm got %b want 000",
                     {pwm_r, pwm_g, pwm_b});
        else passed++;
        total++;
        if (led_en !== 1'b0)
            $display("FAIL rst_led got %b want 0", led_en);
        else passed++;
        total++;
        if (frame_err !== 1'b0)
            $display("FAIL rst_err got %b want 0", frame_err);
        else passed++;
        total++;
        if (cmd_count !== 8'd0)
            $display("FAIL rst_cmd got %0d want 0", cmd_count);
        else passed++;
        resetn = 1'b1;
        hi = 0;
        repeat (600) begin
            @(negedge clk);
            hi += int'(pwm_r) + int'(pwm_g) + int'(pwm_b);
        end
        total++;
        if (hi !== 0)
            $display("FAIL idle_pwm got %0d highs want 0", hi);
        else passed++;
    endtask

    task automatic test_set_enable();
        int e0, hr, hg, hb;
        e0 = errs;
        frame_start();
        send_byte(8'h01);
        send_byte(8'h40);
        send_byte(8'h80);
        send_byte(8'hFF);
        frame_end();
        m_pend[0] = 8'h40;
        m_pend[1] = 8'h80;
        m_pend[2] = 8'hFF;
        m_cmd = m_cmd + 8'd1;
        frame_start();
        send_byte(8'h03);
        send_byte(8'h01);
        m_led = 1'b1;
        m_cmd = m_cmd + 8'd1;
        total++;
        if (led_en !== m_led)
            $display("FAIL en_led got %b want %b", led_en, m_led);
        else passed++;
        frame_end();
        total++;
        if (cmd_count !== m_cmd)
            $display("FAIL set_cmd got %0d want %0d",
                     cmd_count, m_cmd);
        else passed++;
        total++;
        if (errs - e0 !== 0)
            $display("FAIL set_err got %0d want 0", errs - e0);
        else passed++;
        settle();
        measure(hr, hg, hb);
        total++;
        if (hr !== int'(m_act[0]))
            $display("FAIL set_pwm_r got %0d want %0d",
                     hr, m_act[0]);
        else passed++;
        total++;
        if (hg !== int'(m_act[1]))
            $display("FAIL set_pwm_g got %0d want %0d",
                     hg, m_act[1]);
        else passed++;
        total++;
        if (hb !== int'(m_act[2]))
            $display("FAIL set_pwm_b got %0d want %0d",
                     hb, m_act[2]);
        else passed++;
    endtask

    task automatic test_read();
        logic [7:0] exp;
        frame_start();
        total++;
        if (tx_data !== SYNC)
            $display("FAIL rd_pre got %h want %h", tx_data, SYNC);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) send_byte(8'h02);
            else send_byte(8'($urandom_range(0, 255)));
            if (i < 3) exp = m_act[i];
            else exp = 8'h00;
            if (i == 2) m_cmd = m_cmd + 8'd1;
            total++;
            if (tx_data !== exp)
                $display("FAIL rd_tx%0d got %h want %h",
                         i, tx_data, exp);
            else passed++;
        end
        total++;
        if (cmd_count !== m_cmd)
            $display("FAIL rd_cmd got %0d want %0d",
                     cmd_count, m_cmd);
        else passed++;
        frame_end();
        total++;
        if (tx_data !== SYNC)
            $display("FAIL rd_end got %h want %h", tx_data, SYNC);
        else passed++;
    endtask

    task automatic test_partial_set();
        int e0, hr, hg, hb;
        e0 = errs;
        frame_start();
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        frame_active = 1'b0;
        @(negedge clk);
        total++;
        if (frame_err !== 1'b1)
            $display("FAIL part_pulse got %b want 1", frame_err);
        else passed++;
        clk_n(3);
        total++;
        if (errs - e0 !== 1)
            $display("FAIL part_errs got %0d want 1", errs - e0);
        else passed++;
        total++;
        if (cmd_count !== m_cmd)
            $display("FAIL part_cmd got %0d want %0d",
                     cmd_count, m_cmd);
        else passed++;
        settle();
        measure(hr, hg, hb);
        total++;
        if ({hr, hg, hb} !== {int'(m_act[0]), int'(m_act[1]),
                              int'(m_act[2])})
            $display("FAIL part_pwm got %0d/%0d/%0d want %0d/%0d/%0d",
                     hr, hg, hb, m_act[0], m_act[1], m_act[2]);
        else passed++;
    endtask

    task automatic test_unknown();
        int e0;
        e0 = errs;
        frame_start();
        send_byte(8'h7E);
        total++;
        if (tx_data !== 8'h00)
            $display("FAIL unk_tx got %h want 00", tx_data);
        else passed++;
        send_byte(8'h03);
        send_byte(8'h00);
        frame_end();
        total++;
        if (errs - e0 !== 1)
            $display("FAIL unk_errs got %0d want 1", errs - e0);
        else passed++;
        total++;
        if ({led_en, cmd_count} !== {m_led, m_cmd})
            $display("FAIL unk_state got %b/%0d want %b/%0d",
                     led_en, cmd_count, m_led, m_cmd);
        else passed++;
        frame_start();
        send_byte(8'h03);
        send_byte(8'h00);
        frame_end();
        m_led = 1'b0;
        m_cmd = m_cmd + 8'd1;
        total++;
        if (led_en !== m_led)
            $display("FAIL unk_en got %b want %b", led_en, m_led);
        else passed++;
        total++;
        if (cmd_count !== m_cmd)
            $display("FAIL unk_cmd got %0d want %0d",
                     cmd_count, m_cmd);
        else passed++;
        total++;
        if (errs - e0 !== 1)
            $display("FAIL unk_errs2 got %0d want 1", errs - e0);
        else passed++;
    endtask

    task automatic test_outside_frame();
        int e0;
        e0 = errs;
        send_byte(8'h03);
        send_byte(8'h01);
        total++;
        if ({led_en, cmd_count} !== {m_led, m_cmd})
            $display("FAIL out_state got %b/%0d want %b/%0d",
                     led_en, cmd_count, m_led, m_cmd);
        else passed++;
        frame_start();
        send_byte(8'h03);
        frame_active = 1'b0;
        rx_valid     = 1'b1;
        rx_data      = 8'h01;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        clk_n(3);
        total++;
        if ({led_en, cmd_count} !== {m_led, m_cmd})
            $display("FAIL simul_state got %b/%0d want %b/%0d",
                     led_en, cmd_count, m_led, m_cmd);
        else passed++;
        total++;
        if (errs - e0 !== 1)
            $display("FAIL simul_errs got %0d want 1", errs - e0);
        else passed++;
        total++;
        if (tx_data !== SYNC)
            $display("FAIL simul_tx got %h want %h", tx_data, SYNC);
        else passed++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int kind, len, e0, hr, hg, hb;
            logic [7:0] b;
            logic [7:0] exp;
            bit xerr;
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, 5);
            e0   = errs;
            frame_start();
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(0, 255));
                if (i == 0) begin
                    if (kind == 0) b = 8'h01;
                    else if (kind == 1) b = 8'h02;
                    else if (kind == 2) b = 8'h03;
                    else b = 8'($urandom_range(4, 255));
                end
                exp = 8'h00;
                if (kind == 0) begin
                    if (i < 3) exp = SYNC;
                    if (i == 1) m_sh[0] = b;
                    if (i == 2) m_sh[1] = b;
                    if (i == 3) begin
                        m_pend[0] = m_sh[0];
                        m_pend[1] = m_sh[1];
                        m_pend[2] = b;
                        m_cmd = m_cmd + 8'd1;
                    end
                end else if (kind == 1) begin
                    if (i < 3) exp = m_act[i];
                    if (i == 2) m_cmd = m_cmd + 8'd1;
                end else if (kind == 2) begin
                    if (i == 0) exp = SYNC;
                    if (i == 1) begin
                        m_led = b[0];
                        m_cmd = m_cmd + 8'd1;
                    end
                end
                send_byte(b);
                total++;
                if (tx_data !== exp)
                    $display("FAIL rnd%0d_tx%0d got %h want %h",
                             f, i, tx_data, exp);
                else passed++;
            end
            xerr = (kind == 0 && len < 4) ||
                   (kind == 2 && len < 2) || (kind == 3);
            frame_end();
            total++;
            if (errs - e0 !== int'(xerr))
                $display("FAIL rnd%0d_err got %0d want %0d",
                         f, errs - e0, xerr);
            else passed++;
            total++;
            if ({led_en, cmd_count} !== {m_led, m_cmd})
                $display("FAIL rnd%0d_st got %b/%0d want %b/%0d",
                         f, led_en, cmd_count, m_led, m_cmd);
            else passed++;
            settle();
            measure(hr, hg, hb);
            total++;
            if ({hr, hg, hb} !== {int'(m_act[0]), int'(m_act[1]),
                                  int'(m_act[2])})
                $display("FAIL rnd%0d_pwm got %0d/%0d/%0d want %0d/%0d/%0d",
                         f, hr, hg, hb,
                         m_act[0], m_act[1], m_act[2]);
            else passed++;
        end
    endtask

    task automatic test_midperiod();
        bit rs [300];
        bit gs [300];
        bit bs [300];
        int kr, fr, fg, fb, hold_r, hold_g;
        frame_start();
        send_byte(8'h01);
        send_byte(8'h40);
        send_byte(8'h80);
        send_byte(8'hFF);
        frame_end();
        m_pend[0] = 8'h40;
        m_pend[1] = 8'h80;
        m_pend[2] = 8'hFF;
        m_cmd = m_cmd + 8'd1;
        settle();
        frame_start();
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h10);
        for (int k = 0; k < 300; k++) begin
            if (ph == 8'd98) break;
            @(negedge clk);
        end
        total++;
        if (ph !== 8'd98)
            $display("FAIL mid_align got %0d want 98", ph);
        else passed++;
        send_byte(8'h10);
        for (int i = 0; i < 3; i++) m_pend[i] = 8'h10;
        m_cmd = m_cmd + 8'd1;
        frame_end();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            rs[k] = pwm_r;
            gs[k] = pwm_g;
            bs[k] = pwm_b;
        end
        hold_r = 0;
        hold_g = 0;
        for (int k = 0; k < 20; k++) begin
            hold_r += int'(rs[k]);
            hold_g += int'(gs[k]);
        end
        total++;
        if ({hold_r, hold_g} !== {32'd0, 32'd20})
            $display("FAIL mid_hold got r%0d g%0d want r0 g20",
                     hold_r, hold_g);
        else passed++;
        kr = -1;
        for (int k = 0; k < 300; k++)
            if (rs[k] && kr < 0) kr = k;
        total++;
        if (kr < 0)
            $display("FAIL mid_rise got none want one");
        else passed++;
        if (kr >= 0) begin
            fr = -1;
            fg = -1;
            fb = -1;
            for (int k = kr; k < 300; k++) begin
                if (!rs[k] && fr < 0) fr = k;
                if (!gs[k] && fg < 0) fg = k;
                if (!bs[k] && fb < 0) fb = k;
            end
            total++;
            if ({gs[kr], bs[kr]} !== 2'b11)
                $display("FAIL mid_start got %b want 11",
                         {gs[kr], bs[kr]});
            else passed++;
            total++;
            if (fr - kr !== int'(m_pend[0]))
                $display("FAIL mid_width got %0d want %0d",
                         fr - kr, m_pend[0]);
            else passed++;
            total++;
            if ({fg, fb} !== {fr, fr})
                $display("FAIL mid_sync got %0d/%0d want %0d",
                         fg, fb, fr);
            else passed++;
        end
        for (int i = 0; i < 3; i++) m_act[i] = m_pend[i];
    endtask

    task automatic test_async_reset();
        int e0;
        frame_start();
        send_byte(8'h03);
        send_byte(8'h01);
        frame_end();
        frame_start();
        send_byte(8'h01);
        #2 resetn = 1'b0;
        model_reset();
        #1;
        total++;
        if ({tx_data, pwm_r, pwm_g, pwm_b} !== {SYNC, 3'b000})
            $display("FAIL ares_out got %h/%b want %h/000",
                     tx_data, {pwm_r, pwm_g, pwm_b}, SYNC);
        else passed++;
        total++;
        if ({led_en, frame_err, cmd_count} !== 10'd0)
            $display("FAIL ares_st got %b/%b/%0d want 0/0/0",
                     led_en, frame_err, cmd_count);
        else passed++;
        @(negedge clk);
        resetn = 1'b1;
        clk_n(2);
        e0 = errs;
        send_byte(8'h03);
        send_byte(8'h01);
        m_led = 1'b1;
        m_cmd = m_cmd + 8'd1;
        total++;
        if ({led_en, cmd_count} !== {m_led, m_cmd})
            $display("FAIL ares_cmd got %b/%0d want %b/%0d",
                     led_en, cmd_count, m_led, m_cmd);
        else passed++;
        frame_end();
        total++;
        if ({errs - e0, 24'd0, tx_data} !== {32'd0, 24'd0, SYNC})
            $display("FAIL ares_end got %0d/%h want 0/%h",
                     errs - e0, tx_data, SYNC);
        else passed++;
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        errs         = 0;
        resetn       = 1'b1;
        frame_active = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        test_reset();
        test_set_enable();
        test_read();
        test_partial_set();
        test_unknown();
        test_outside_frame();
        test_random();
        test_midperiod();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
